rcu_pll_ctrl: RTL and testbench
===============================

# rcu_pll_ctrl

Sequencer for the RCU PLL and the core-clock source switch. Runs on the reference clock and powers the PLL up with a latched configuration. It waits for a stable lock, then hands the glitch-free core-clock mux over to the PLL and back. It also detects lock timeout and lock loss, and reports them through sticky status.

## Interface
- `CFG_WIDTH`, default 4: width of the PLL configuration word.
- `LOCK_TIMEOUT`, default 4096: cycles allowed in PWRUP and in SWITCH before FAULT.
- `LOCK_STABLE`, default 64: consecutive synced-lock cycles required before switching.

Ports:
- `clk_i` in 1: reference clock; every flop is in this domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: level request to run the core from the PLL.
- `cfg_i` in CFG_WIDTH: requested PLL configuration.
- `cfg_upd_i` in 1: one-cycle pulse that applies a new `cfg_i` while in RUN.
- `err_clr_i` in 1: pulse that clears FAULT and `err_o`.
- `pll_lock_i` in 1: PLL lock, asynchronous to `clk_i`.
- `sel_ack_i` in 1: current select reported by the glitch-free mux, synchronous to `clk_i`.
- `pll_en_o` out 1: PLL enable.
- `pll_cfg_o` out CFG_WIDTH: latched configuration sent to the PLL.
- `sel_pll_o` out 1: mux select; 1 selects the PLL clock.
- `locked_o` out 1: high only in RUN.
- `busy_o` out 1: high in PWRUP, STABLE, SWITCH and UNSW.
- `err_o` out 1: sticky error flag.
- `state_o` out 3: current state encoding.

## Operation
- `pll_lock_i` passes through a 2-flop synchronizer; `lock_s` is the synchronizer output.
- One shared counter `cnt` of width $clog2(LOCK_TIMEOUT+1) is cleared on every state change.
- Flag `fault_pend` records that UNSW must exit to FAULT instead of REF.
- FSM states and encoding:
  - REF = 0: `pll_en_o` = 0, `sel_pll_o` = 0.
    - If `en_i` is high and `err_o` is low: `pll_cfg_o` <= `cfg_i`, go to PWRUP.
  - PWRUP = 1: `pll_en_o` = 1.
    - `lock_s` high: go to STABLE.
    - Else `cnt` == LOCK_TIMEOUT-1: go to FAULT.
    - `en_i` low (lowest priority): go to REF.
  - STABLE = 2: `cnt` counts consecutive `lock_s` cycles.
    - `lock_s` low: go to PWRUP; its timeout restarts.
    - `cnt` == LOCK_STABLE-1 with `lock_s` high: go to SWITCH.
    - `en_i` low: go to REF.
  - SWITCH = 3: `sel_pll_o` = 1.
    - `sel_ack_i` high: go to RUN.
    - Timeout or `lock_s` low: set `fault_pend`, go to UNSW.
    - `en_i` low: go to UNSW.
  - RUN = 4: `sel_pll_o` = 1, `locked_o` = 1.
    - `lock_s` low: set `fault_pend`, go to UNSW. This has highest priority.
    - Else `en_i` low or `cfg_upd_i`: go to UNSW.
  - UNSW = 5: `sel_pll_o` = 0, `pll_en_o` = 1.
    - `sel_ack_i` low: go to FAULT if `fault_pend`, else REF; clear `fault_pend`.
    - No timeout: the mux must return to the reference clock.
  - FAULT = 6: `pll_en_o` = 0, `sel_pll_o` = 0, `err_o` set.
    - `err_clr_i`: clear `err_o`, go to REF.
- `cfg_upd_i` outside RUN is ignored, because `cfg_i` is sampled again at the next REF exit.
- A configuration change therefore always costs at least one REF cycle with `pll_en_o` = 0.
- If `err_clr_i` arrives in the same cycle as a fault event, `err_o` still ends set.
- Encoding 7 is illegal and recovers to REF.

## Timing
- Reset values: state REF, `pll_en_o` 0, `sel_pll_o` 0, `pll_cfg_o` 0, `locked_o` 0, `busy_o` 0, `err_o` 0, `fault_pend` 0, synchronizer 0.
- All outputs are registered or decoded from the state register only; there are no input-to-output combinational paths.
- `en_i` rising to `pll_en_o` high: 1 cycle.
- `pll_lock_i` rising to the STABLE entry: 3 cycles (2 synchronizer cycles plus the state update).
- `sel_pll_o` rises exactly LOCK_STABLE cycles after STABLE entry when lock is held.
- Lock loss in RUN:
  - `lock_s` low to `sel_pll_o` low: 1 cycle.
  - `locked_o` also falls 1 cycle after `lock_s` low.
- Asserting `rst_i` mid-sequence immediately forces `sel_pll_o` and `pll_en_o` to 0.

## Structure
- `rcu_pkg` holds:
  - The state enum `rcu_pll_state_e` with the encodings above.
  - The default constants for LOCK_TIMEOUT and LOCK_STABLE.
- The synchronizer is a separate sub-module, `rcu_sync2` (2-flop, async active-high reset to 0), reusable by other RCU blocks.

## Test plan
Unless stated otherwise, LOCK_TIMEOUT = 16 and LOCK_STABLE = 4.
- Nominal bring-up: `en_i` = 1, `cfg_i` = 0x5; lock rises 5 cycles later; mux acks 2 cycles after `sel_pll_o`.
  - Required: `pll_cfg_o` = 0x5, `sel_pll_o` rises 7 cycles after lock, `locked_o` = 1, `busy_o` = 0, state 4.
- Lock timeout: lock is never asserted.
  - Required: FAULT 16 cycles after PWRUP entry, `err_o` = 1, `pll_en_o` = 0.
  - A new `en_i` is ignored until `err_clr_i`.
- Lock glitch: lock drops for 1 cycle during STABLE.
  - Required: return to PWRUP, then the full 4-cycle stable window before SWITCH.
- Reconfigure: in RUN, `cfg_i` = 0xA with `cfg_upd_i` pulse.
  - Required: UNSW, then REF with `pll_en_o` = 0 for at least 1 cycle, then PWRUP with `pll_cfg_o` = 0xA, then RUN again.
- Lock loss in RUN: lock drops.
  - Required: `sel_pll_o` low 1 cycle after `lock_s`, FAULT after `sel_ack_i` falls.
  - Simultaneous `err_clr_i` leaves `err_o` = 1.
- Reset mid-SWITCH: `rst_i` pulse.
  - Required: all outputs at their reset values asynchronously, state_o = 0.

Source files
------------

// File: rtl/rcu_pkg.sv
// Shared types and defaults for the RCU PLL sequencer family.
package rcu_pkg;

    typedef enum logic [2:0] {
        ST_REF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_STABLE = 3'd2,
        ST_SWITCH = 3'd3,
        ST_RUN    = 3'd4,
        ST_UNSW   = 3'd5,
        ST_FAULT  = 3'd6
    } rcu_pll_state_e;

    localparam int unsigned LOCK_TIMEOUT_DEF = 32'd4096;
    localparam int unsigned LOCK_STABLE_DEF  = 32'd64;

endpackage

// File: rtl/rcu_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module rcu_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rcu_pll_ctrl.sv
// PLL power-up / lock qualification sequencer driving the glitch-free core-clock mux.
module rcu_pll_ctrl
    import rcu_pkg::*;
#(
    parameter int unsigned CFG_WIDTH    = 32'd4,
    parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int unsigned LOCK_STABLE  = LOCK_STABLE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CFG_WIDTH-1:0] cfg_i,
    input  logic                 cfg_upd_i,
    input  logic                 err_clr_i,
    input  logic                 pll_lock_i,
    input  logic                 sel_ack_i,
    output logic                 pll_en_o,
    output logic [CFG_WIDTH-1:0] pll_cfg_o,
    output logic                 sel_pll_o,
    output logic                 locked_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [2:0]           state_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 32'd1);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_STB = CNT_W'(LOCK_STABLE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rcu_pll_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic                 err_q, err_d;
    logic                 fpend_q, fpend_d;
    logic                 lock_s;

    rcu_sync2 u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    // State, counter, latched configuration and sticky flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_REF;
            cnt_q   <= {CNT_W{1'b0}};
            cfg_q   <= {CFG_WIDTH{1'b0}};
            err_q   <= 1'b0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            fpend_q <= fpend_d;
        end
    end

    // Next-state logic; the shared counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        fpend_d = fpend_q;
        err_d   = err_q;
        case (state_q)
            ST_REF: begin
                if (en_i && !err_q) begin
                    cfg_d   = cfg_i;
                    state_d = ST_PWRUP;
                end else begin
                    state_d = ST_REF;
                end
            end
            ST_PWRUP: begin
                if (lock_s)                state_d = ST_STABLE;
                else if (cnt_q == CNT_TMO) state_d = ST_FAULT;
                else if (!en_i)            state_d = ST_REF;
                else                       state_d = ST_PWRUP;
            end
            ST_STABLE: begin
                if (!lock_s)               state_d = ST_PWRUP;
                else if (cnt_q == CNT_STB) state_d = ST_SWITCH;
                else if (!en_i)            state_d = ST_REF;
                else                       state_d = ST_STABLE;
            end
            ST_SWITCH: begin
                if (sel_ack_i) begin
                    state_d = ST_RUN;
                end else if ((cnt_q == CNT_TMO) || !lock_s) begin
                    fpend_d = 1'b1;
                    state_d = ST_UNSW;
                end else if (!en_i) begin
                    state_d = ST_UNSW;
                end else begin
                    state_d = ST_SWITCH;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    fpend_d = 1'b1;
                    state_d = ST_UNSW;
                end else if (!en_i || cfg_upd_i) begin
                    state_d = ST_UNSW;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_UNSW: begin
                // No timeout here: the PLL must keep running until the mux is back on ref.
                if (!sel_ack_i) begin
                    state_d = fpend_q ? ST_FAULT : ST_REF;
                    fpend_d = 1'b0;
                end else begin
                    state_d = ST_UNSW;
                end
            end
            ST_FAULT: begin
                if (err_clr_i) begin
                    err_d   = 1'b0;
                    state_d = ST_REF;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_REF;
            end
        endcase

        // A fault entry wins over a coincident clear.
        if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        if (state_d != state_q)   cnt_d = {CNT_W{1'b0}};
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        else                       cnt_d = cnt_q;
    end

    // Output decode from the state register only.
    always_comb begin
        pll_en_o  = 1'b0;
        sel_pll_o = 1'b0;
        locked_o  = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            ST_PWRUP, ST_STABLE: begin
                pll_en_o = 1'b1;
                busy_o   = 1'b1;
            end
            ST_SWITCH: begin
                pll_en_o  = 1'b1;
                sel_pll_o = 1'b1;
                busy_o    = 1'b1;
            end
            ST_RUN: begin
                pll_en_o  = 1'b1;
                sel_pll_o = 1'b1;
                locked_o  = 1'b1;
            end
            ST_UNSW: begin
                pll_en_o = 1'b1;
                busy_o   = 1'b1;
            end
            default: begin
                pll_en_o  = 1'b0;
                sel_pll_o = 1'b0;
            end
        endcase
    end

    assign pll_cfg_o = cfg_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rcu_pll_ctrl.sv
// Scoreboard bench for rcu_pll_ctrl: expected state sequences queued per scenario, popped each cycle.
module tb_rcu_pll_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [3:0] cfg_i;
    logic       cfg_upd_i;
    logic       err_clr_i;
    logic       pll_lock_i;
    logic       sel_ack_i;
    logic       pll_en_o;
    logic [3:0] pll_cfg_o;
    logic       sel_pll_o;
    logic       locked_o;
    logic       busy_o;
    logic       err_o;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];

    rcu_pll_ctrl #(.CFG_WIDTH(4), .LOCK_TIMEOUT(16), .LOCK_STABLE(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cfg_i(cfg_i), .cfg_upd_i(cfg_upd_i),
        .err_clr_i(err_clr_i), .pll_lock_i(pll_lock_i), .sel_ack_i(sel_ack_i),
        .pll_en_o(pll_en_o), .pll_cfg_o(pll_cfg_o), .sel_pll_o(sel_pll_o),
        .locked_o(locked_o), .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected {state, pll_en, sel_pll, locked, busy, err} for a given state.
    function automatic logic [7:0] exp_vec(input logic [2:0] st);
        logic pe, sl, lk, bz, er;
        pe = (st >= 3'd1) && (st <= 3'd5);
        sl = (st == 3'd3) || (st == 3'd4);
        lk = (st == 3'd4);
        bz = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd5);
        er = (st == 3'd6);
        return {st, pe, sl, lk, bz, er};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {state_o, pll_en_o, sel_pll_o, locked_o, busy_o, err_o};
    endfunction

    task automatic push_n(input logic [2:0] st, input int n);
        repeat (n) exp_q.push_back(st);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; cfg_i = 4'h0; cfg_upd_i = 1'b0;
        err_clr_i = 1'b0; pll_lock_i = 1'b0; sel_ack_i = 1'b0;
        step(); step();
        tests++;
        if ({obs_vec(), pll_cfg_o} !== {exp_vec(3'd0), 4'h0}) begin
            fails++;
            $display("FAIL reset: got %b/%h required %b/%h", obs_vec(), pll_cfg_o, exp_vec(3'd0), 4'h0);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        logic [2:0] st;
        push_n(3'd1, 7); push_n(3'd2, 4); push_n(3'd3, 2); push_n(3'd4, 1);
        en_i = 1'b1; cfg_i = 4'h5;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL nominal cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
            if (k == 5)  pll_lock_i = 1'b1;
            if (k == 13) sel_ack_i = 1'b1;
        end
        tests++;
        if (pll_cfg_o !== 4'h5) begin
            fails++;
            $display("FAIL nominal_cfg: got %h required %h", pll_cfg_o, 4'h5);
        end
    endtask

    task automatic test_reconfig();
        logic [2:0] st;
        push_n(3'd5, 1); push_n(3'd0, 1); push_n(3'd1, 1); push_n(3'd2, 4);
        push_n(3'd3, 1); push_n(3'd4, 1);
        cfg_i = 4'hA; cfg_upd_i = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL reconfig cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
            if (k == 1) begin cfg_upd_i = 1'b0; sel_ack_i = 1'b0; end
            if (k == 8) sel_ack_i = 1'b1;
        end
        tests++;
        if (pll_cfg_o !== 4'hA) begin
            fails++;
            $display("FAIL reconfig_cfg: got %h required %h", pll_cfg_o, 4'hA);
        end
    endtask

    task automatic test_lock_loss();
        logic [2:0] st;
        push_n(3'd4, 2); push_n(3'd5, 2); push_n(3'd6, 2);
        pll_lock_i = 1'b0;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL lock_loss cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
            if (k == 4) begin sel_ack_i = 1'b0; err_clr_i = 1'b1; end
            if (k == 5) err_clr_i = 1'b0;
        end
        en_i = 1'b0; err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        tests++;
        if (obs_vec() !== exp_vec(3'd0)) begin
            fails++;
            $display("FAIL fault_clear: got %b required %b", obs_vec(), exp_vec(3'd0));
        end
    endtask

    task automatic test_timeout();
        logic [2:0] st;
        push_n(3'd1, 16); push_n(3'd6, 3); push_n(3'd0, 1); push_n(3'd1, 1); push_n(3'd0, 1);
        en_i = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL timeout cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
            if (k == 19) err_clr_i = 1'b1;
            if (k == 20) err_clr_i = 1'b0;
            if (k == 21) en_i = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [2:0] st;
        push_n(3'd1, 3); push_n(3'd2, 3); push_n(3'd1, 1); push_n(3'd2, 4);
        push_n(3'd3, 1); push_n(3'd5, 1); push_n(3'd0, 1);
        en_i = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL glitch cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
            if (k == 1)  pll_lock_i = 1'b1;
            if (k == 4)  pll_lock_i = 1'b0;
            if (k == 5)  pll_lock_i = 1'b1;
            if (k == 12) en_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_switch();
        logic [2:0] st;
        push_n(3'd1, 1); push_n(3'd2, 4); push_n(3'd3, 1);
        en_i = 1'b1;
        for (int k = 1; exp_q.size() > 0; k++) begin
            step();
            st = exp_q.pop_front();
            tests++;
            if (obs_vec() !== exp_vec(st)) begin
                fails++;
                $display("FAIL pre_reset cyc %0d: got %b required %b", k, obs_vec(), exp_vec(st));
            end
        end
        #2 rst_i = 1'b1;
        #1;
        tests++;
        if ({obs_vec(), pll_cfg_o} !== {exp_vec(3'd0), 4'h0}) begin
            fails++;
            $display("FAIL async_reset: got %b/%h required %b/%h", obs_vec(), pll_cfg_o, exp_vec(3'd0), 4'h0);
        end
        en_i = 1'b0; pll_lock_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reconfig();
        test_lock_loss();
        test_timeout();
        test_glitch();
        test_reset_mid_switch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
